// File: rtl/main_control_unit.sv
// main_control_unit: multi-cycle instruction sequencer for a small RV32 core.
// Steps each instruction through FETCH -> DECODE -> EXEC and, depending on
// the opcode, a load/store handshake with the LSU or a wait on the
// multiplier. Unknown opcodes land in an absorbing TRAP state.
//
// Ports
//   MCU_CLOCK_50         clock, rising edge
//   MCU_RESET_InLow      asynchronous active-low reset
//   MCU_Instr_InBUS      instruction word from instruction memory
//   MCU_Imem_Ready       instruction memory handshake (word valid this cycle)
//   MCU_Lsu_Ready        LSU accepted the memory request
//   MCU_Lsu_Rdata_Valid  load data returned this cycle
//   MCU_Mul_Done         multiplier result valid this cycle
//   MCU_State_OutBUS     current state (to the decode unit)
//   MCU_Ir_OutBUS        instruction register
//   MCU_Imem_Req         fetch request (combinational, FETCH only)
//   MCU_Pc_Write         PC update / retirement strobe (combinational)
//   MCU_Lsu_Valid        memory request valid (combinational)
//   MCU_Load_Wb_En       register-file write enable for load data (combinational)
//   MCU_Trap             illegal-opcode flag, held until reset
//   MCU_Instret_OutBUS   retired-instruction counter
module main_control_unit (
  input  logic        MCU_CLOCK_50,
  input  logic        MCU_RESET_InLow,
  input  logic [31:0] MCU_Instr_InBUS,
  input  logic        MCU_Imem_Ready,
  input  logic        MCU_Lsu_Ready,
  input  logic        MCU_Lsu_Rdata_Valid,
  input  logic        MCU_Mul_Done,
  output logic [2:0]  MCU_State_OutBUS,
  output logic [31:0] MCU_Ir_OutBUS,
  output logic        MCU_Imem_Req,
  output logic        MCU_Pc_Write,
  output logic        MCU_Lsu_Valid,
  output logic        MCU_Load_Wb_En,
  output logic        MCU_Trap,
  output logic [31:0] MCU_Instret_OutBUS
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic [2:0] {
    ST_RESET    = 3'b000,
    ST_FETCH    = 3'b001,
    ST_DECODE   = 3'b010,
    ST_EXEC     = 3'b011,
    ST_LSU_REQ  = 3'b100,
    ST_LSU_RESP = 3'b101,
    ST_MUL_WAIT = 3'b110,
    ST_TRAP     = 3'b111
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] instret;
  logic            ir_load;

  logic [OPW-1:0]  opcode;
  logic [OPW-1:0]  funct7;
  logic            is_mem;
  logic            is_mul;
  logic            is_simple;

  // Opcode classification from the latched instruction.
  always_comb begin
    opcode    = ir[6:0];
    funct7    = ir[31:25];
    // 0?00011: LOAD / STORE
    is_mem    = (opcode[6] == 1'b0) && (opcode[4:0] == 5'b00011);
    is_mul    = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
    // 0?10111 LUI/AUIPC, 110?111 JAL/JALR, BRANCH, OP-IMM, OP (non-MUL)
    is_simple = ((opcode[6] == 1'b0) && (opcode[4:0] == 5'b10111))
             || ((opcode[6:4] == 3'b110) && (opcode[2:0] == 3'b111))
             || (opcode == 7'b1100011)
             || (opcode == 7'b0010011)
             || ((opcode == 7'b0110011) && !is_mul);
  end

  // Next-state and strobe logic.
  always_comb begin
    state_nxt      = state;
    ir_load        = 1'b0;
    MCU_Imem_Req   = 1'b0;
    MCU_Pc_Write   = 1'b0;
    MCU_Lsu_Valid  = 1'b0;
    MCU_Load_Wb_En = 1'b0;
    case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        MCU_Imem_Req = 1'b1;
        if (MCU_Imem_Ready) begin
          ir_load   = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (is_mem) begin
          state_nxt = ST_LSU_REQ;
        end else if (is_mul) begin
          state_nxt = ST_MUL_WAIT;
        end else if (is_simple) begin
          MCU_Pc_Write = 1'b1;
          state_nxt    = ST_FETCH;
        end else begin
          state_nxt = ST_TRAP;
        end
      end
      ST_LSU_REQ: begin
        MCU_Lsu_Valid = 1'b1;
        if (MCU_Lsu_Ready) begin
          // IR[5] separates STORE (0100011) from LOAD (0000011)
          if (ir[5]) begin
            MCU_Pc_Write = 1'b1;
            state_nxt    = ST_FETCH;
          end else begin
            state_nxt = ST_LSU_RESP;
          end
        end
      end
      ST_LSU_RESP: begin
        if (MCU_Lsu_Rdata_Valid) begin
          MCU_Load_Wb_En = 1'b1;
          MCU_Pc_Write   = 1'b1;
          state_nxt      = ST_FETCH;
        end
      end
      ST_MUL_WAIT: begin
        if (MCU_Mul_Done) begin
          MCU_Pc_Write = 1'b1;
          state_nxt    = ST_FETCH;
        end
      end
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_RESET;
    endcase
  end

  // State, instruction register and retirement counter.
  always_ff @(posedge MCU_CLOCK_50 or negedge MCU_RESET_InLow) begin
    if (!MCU_RESET_InLow) begin
      state   <= ST_RESET;
      ir      <= '0;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) begin
        ir <= MCU_Instr_InBUS;
      end
      if (MCU_Pc_Write) begin
        instret <= instret + XLEN'(1);
      end
    end
  end

  assign MCU_State_OutBUS   = state;
  assign MCU_Ir_OutBUS      = ir;
  assign MCU_Instret_OutBUS = instret;
  assign MCU_Trap           = (state == ST_TRAP);

endmodule

// File: tb/tb_main_control_unit.sv
// Testbench for main_control_unit: opcode table walked through the full
// instruction flow, retirement scoreboard, and hand-written sequences for
// delayed LSU handshakes, counter wrap, trap absorption and async reset.
module tb_main_control_unit;

  localparam logic [2:0] S_RESET    = 3'b000;
  localparam logic [2:0] S_FETCH    = 3'b001;
  localparam logic [2:0] S_DECODE   = 3'b010;
  localparam logic [2:0] S_EXEC     = 3'b011;
  localparam logic [2:0] S_LSU_REQ  = 3'b100;
  localparam logic [2:0] S_LSU_RESP = 3'b101;
  localparam logic [2:0] S_MUL_WAIT = 3'b110;
  localparam logic [2:0] S_TRAP     = 3'b111;

  logic        MCU_CLOCK_50;
  logic        MCU_RESET_InLow;
  logic [31:0] MCU_Instr_InBUS;
  logic        MCU_Imem_Ready;
  logic        MCU_Lsu_Ready;
  logic        MCU_Lsu_Rdata_Valid;
  logic        MCU_Mul_Done;
  logic [2:0]  MCU_State_OutBUS;
  logic [31:0] MCU_Ir_OutBUS;
  logic        MCU_Imem_Req;
  logic        MCU_Pc_Write;
  logic        MCU_Lsu_Valid;
  logic        MCU_Load_Wb_En;
  logic        MCU_Trap;
  logic [31:0] MCU_Instret_OutBUS;

  main_control_unit dut (
    .MCU_CLOCK_50        (MCU_CLOCK_50),
    .MCU_RESET_InLow     (MCU_RESET_InLow),
    .MCU_Instr_InBUS     (MCU_Instr_InBUS),
    .MCU_Imem_Ready      (MCU_Imem_Ready),
    .MCU_Lsu_Ready       (MCU_Lsu_Ready),
    .MCU_Lsu_Rdata_Valid (MCU_Lsu_Rdata_Valid),
    .MCU_Mul_Done        (MCU_Mul_Done),
    .MCU_State_OutBUS    (MCU_State_OutBUS),
    .MCU_Ir_OutBUS       (MCU_Ir_OutBUS),
    .MCU_Imem_Req        (MCU_Imem_Req),
    .MCU_Pc_Write        (MCU_Pc_Write),
    .MCU_Lsu_Valid       (MCU_Lsu_Valid),
    .MCU_Load_Wb_En      (MCU_Load_Wb_En),
    .MCU_Trap            (MCU_Trap),
    .MCU_Instret_OutBUS  (MCU_Instret_OutBUS)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  exec_next;
    logic        exec_pc;
    logic        is_load;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int          checks = 0;
  int          errors = 0;
  logic        sb_q [$];
  logic        mon_wb;
  logic [31:0] exp_instret;
  int          valid_cycles;

  initial begin
    MCU_CLOCK_50 = 1'b0;
    forever #5 MCU_CLOCK_50 = ~MCU_CLOCK_50;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge MCU_CLOCK_50);
  endtask

  task automatic idle_inputs();
    MCU_Imem_Ready      = 1'b0;
    MCU_Lsu_Ready       = 1'b0;
    MCU_Lsu_Rdata_Valid = 1'b0;
    MCU_Mul_Done        = 1'b0;
  endtask

  // Assert reset, verify reset values, release, and land in FETCH (+1 after negedge).
  task automatic do_reset();
    MCU_RESET_InLow = 1'b0;
    idle_inputs();
    sb_q.delete();
    exp_instret = 32'h0;
    #1;
    chk3("rst_state", MCU_State_OutBUS, S_RESET);
    chk32("rst_ir", MCU_Ir_OutBUS, 32'h0);
    chk32("rst_instret", MCU_Instret_OutBUS, 32'h0);
    chk1("rst_trap", MCU_Trap, 1'b0);
    chk1("rst_imem_req", MCU_Imem_Req, 1'b0);
    chk1("rst_pc_write", MCU_Pc_Write, 1'b0);
    chk1("rst_lsu_valid", MCU_Lsu_Valid, 1'b0);
    chk1("rst_load_wb", MCU_Load_Wb_En, 1'b0);
    tick();
    MCU_Imem_Ready  = 1'b1;
    MCU_Instr_InBUS = 32'hDEADBEEF;
    #1;
    chk3("rst_hold_state", MCU_State_OutBUS, S_RESET);
    chk1("rst_hold_imem_req", MCU_Imem_Req, 1'b0);
    tick();
    chk32("rst_hold_ir", MCU_Ir_OutBUS, 32'h0);
    MCU_Imem_Ready  = 1'b0;
    MCU_RESET_InLow = 1'b1;
    #1;
    chk3("rst_release_state", MCU_State_OutBUS, S_RESET);
    tick();
    #1;
    chk3("rst_to_fetch", MCU_State_OutBUS, S_FETCH);
  endtask

  // Fetch handshake in the current FETCH cycle; returns at EXEC +1.
  task automatic fetch_issue(input logic [31:0] instr, input logic retire, input logic wb);
    MCU_Instr_InBUS = instr;
    MCU_Imem_Ready  = 1'b1;
    if (retire) sb_q.push_back(wb);
    #1;
    chk3("fetch_state", MCU_State_OutBUS, S_FETCH);
    chk1("fetch_imem_req", MCU_Imem_Req, 1'b1);
    tick();
    // Ready pulse with a different word in DECODE must not touch the IR
    MCU_Instr_InBUS = 32'h5A5A5A5A;
    #1;
    chk3("decode_state", MCU_State_OutBUS, S_DECODE);
    chk32("decode_ir", MCU_Ir_OutBUS, instr);
    chk1("decode_imem_req", MCU_Imem_Req, 1'b0);
    tick();
    MCU_Imem_Ready = 1'b0;
    #1;
    chk3("exec_state", MCU_State_OutBUS, S_EXEC);
    chk32("exec_ir", MCU_Ir_OutBUS, instr);
  endtask

  // Retirement scoreboard: every strobe must match a queued expectation.
  always @(negedge MCU_CLOCK_50) begin
    #3;
    if (MCU_RESET_InLow && (MCU_Pc_Write || MCU_Load_Wb_En)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected pc_write=%b load_wb_en=%b required no retirement t=%0t",
                 MCU_Pc_Write, MCU_Load_Wb_En, $time);
      end else begin
        mon_wb = sb_q.pop_front();
        if (!MCU_Pc_Write || (MCU_Load_Wb_En !== mon_wb)) begin
          errors++;
          $display("FAIL retire_strobes pc_write=%b load_wb_en=%b required pc_write=1 load_wb_en=%b t=%0t",
                   MCU_Pc_Write, MCU_Load_Wb_En, mon_wb, $time);
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{32'h00500093, S_FETCH,    1'b1, 1'b0}; // ADDI
    vecs[1]  = '{32'h000010B7, S_FETCH,    1'b1, 1'b0}; // LUI
    vecs[2]  = '{32'h00000097, S_FETCH,    1'b1, 1'b0}; // AUIPC
    vecs[3]  = '{32'h0000006F, S_FETCH,    1'b1, 1'b0}; // JAL
    vecs[4]  = '{32'h00008067, S_FETCH,    1'b1, 1'b0}; // JALR
    vecs[5]  = '{32'h00000063, S_FETCH,    1'b1, 1'b0}; // BEQ
    vecs[6]  = '{32'h002081B3, S_FETCH,    1'b1, 1'b0}; // ADD
    vecs[7]  = '{32'h402081B3, S_FETCH,    1'b1, 1'b0}; // SUB
    vecs[8]  = '{32'h022081B3, S_MUL_WAIT, 1'b0, 1'b0}; // MUL
    vecs[9]  = '{32'h0000A103, S_LSU_REQ,  1'b0, 1'b1}; // LW
    vecs[10] = '{32'h0020A023, S_LSU_REQ,  1'b0, 1'b0}; // SW
    vecs[11] = '{32'h0000000F, S_TRAP,     1'b0, 1'b0}; // FENCE
    vecs[12] = '{32'h00000007, S_TRAP,     1'b0, 1'b0}; // 0000111 near LOAD
    vecs[13] = '{32'h00000053, S_TRAP,     1'b0, 1'b0}; // 1010011
    vecs[14] = '{32'h00000077, S_TRAP,     1'b0, 1'b0}; // 1110111 near JAL

    MCU_RESET_InLow = 1'b0;
    MCU_Instr_InBUS = 32'h0;
    idle_inputs();
    exp_instret = 32'h0;
    do_reset();

    // Opcode table through the whole flow
    for (int i = 0; i < NVEC; i++) begin
      fetch_issue(vecs[i].instr, vecs[i].exec_next != S_TRAP, vecs[i].is_load);
      chk1("exec_pc_write", MCU_Pc_Write, vecs[i].exec_pc);
      tick();
      #1;
      chk3("exec_next_state", MCU_State_OutBUS, vecs[i].exec_next);
      case (vecs[i].exec_next)
        S_LSU_REQ: begin
          tick();
          MCU_Lsu_Ready = 1'b1;
          #1;
          chk1("lsu_valid", MCU_Lsu_Valid, 1'b1);
          chk1("lsu_accept_pc", MCU_Pc_Write, !vecs[i].is_load);
          tick();
          MCU_Lsu_Ready = 1'b0;
          if (vecs[i].is_load) begin
            #1;
            chk3("lsu_resp_state", MCU_State_OutBUS, S_LSU_RESP);
            MCU_Lsu_Rdata_Valid = 1'b1;
            #1;
            chk1("load_wb_en", MCU_Load_Wb_En, 1'b1);
            tick();
            MCU_Lsu_Rdata_Valid = 1'b0;
          end
          #1;
          chk3("lsu_done_state", MCU_State_OutBUS, S_FETCH);
        end
        S_MUL_WAIT: begin
          chk1("mul_wait_pc", MCU_Pc_Write, 1'b0);
          tick();
          MCU_Mul_Done = 1'b1;
          #1;
          chk1("mul_done_pc", MCU_Pc_Write, 1'b1);
          tick();
          MCU_Mul_Done = 1'b0;
          #1;
          chk3("mul_done_state", MCU_State_OutBUS, S_FETCH);
        end
        S_TRAP: begin
          chk1("trap_flag", MCU_Trap, 1'b1);
          do_reset();
        end
        default: ;
      endcase
      if (vecs[i].exec_next != S_TRAP) exp_instret = exp_instret + 32'd1;
      chk32("instret", MCU_Instret_OutBUS, exp_instret);
    end

    // LW: Lsu_Ready after 3 wait cycles, Rdata_Valid 2 cycles after that
    fetch_issue(32'h0000A103, 1'b1, 1'b1);
    valid_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      MCU_Lsu_Ready       = (c == 3);
      MCU_Lsu_Rdata_Valid = (c != 3); // not sampled in LSU_REQ
      MCU_Mul_Done        = (c != 3);
      #1;
      chk3("lw_req_state", MCU_State_OutBUS, S_LSU_REQ);
      if (MCU_Lsu_Valid) valid_cycles++;
      chk1("lw_req_load_wb", MCU_Load_Wb_En, 1'b0);
    end
    chk32("lw_valid_cycles", 32'(valid_cycles), 32'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      MCU_Lsu_Ready       = (c != 2); // not sampled in LSU_RESP
      MCU_Imem_Ready      = (c != 2);
      MCU_Mul_Done        = 1'b0;
      MCU_Instr_InBUS     = 32'hFFFFFFFF;
      MCU_Lsu_Rdata_Valid = (c == 2);
      #1;
      chk3("lw_resp_state", MCU_State_OutBUS, S_LSU_RESP);
      chk1("lw_resp_wb", MCU_Load_Wb_En, c == 2);
      chk1("lw_resp_pc", MCU_Pc_Write, c == 2);
      chk1("lw_resp_lsu_valid", MCU_Lsu_Valid, 1'b0);
    end
    tick();
    idle_inputs();
    #1;
    chk3("lw_done_state", MCU_State_OutBUS, S_FETCH);
    chk32("lw_ir_stable", MCU_Ir_OutBUS, 32'h0000A103);
    exp_instret = exp_instret + 32'd1;
    chk32("lw_instret", MCU_Instret_OutBUS, exp_instret);

    // SW accepted in the first LSU_REQ cycle: no LSU_RESP
    fetch_issue(32'h0020A023, 1'b1, 1'b0);
    tick();
    MCU_Lsu_Ready = 1'b1;
    #1;
    chk1("sw_lsu_valid", MCU_Lsu_Valid, 1'b1);
    chk1("sw_pc_write", MCU_Pc_Write, 1'b1);
    chk1("sw_load_wb", MCU_Load_Wb_En, 1'b0);
    tick();
    MCU_Lsu_Ready = 1'b0;
    #1;
    chk3("sw_next_state", MCU_State_OutBUS, S_FETCH);
    chk1("sw_load_wb_after", MCU_Load_Wb_En, 1'b0);
    exp_instret = exp_instret + 32'd1;

    // Counter wrap: preload FFFFFFFE, retire two
    force dut.instret = 32'hFFFFFFFE;
    #1;
    release dut.instret;
    exp_instret = 32'hFFFFFFFE;
    chk32("wrap_preload", MCU_Instret_OutBUS, exp_instret);
    for (int k = 0; k < 2; k++) begin
      fetch_issue(32'h00500093, 1'b1, 1'b0);
      chk1("wrap_pc_write", MCU_Pc_Write, 1'b1);
      tick();
      #1;
      exp_instret = exp_instret + 32'd1;
      chk32("wrap_count", MCU_Instret_OutBUS, exp_instret);
    end
    chk32("wrap_zero", MCU_Instret_OutBUS, 32'h00000000);

    // Illegal opcode 1111111: TRAP absorbs everything
    fetch_issue(32'h0000007F, 1'b0, 1'b0);
    chk1("trap_exec_pc", MCU_Pc_Write, 1'b0);
    tick();
    #1;
    chk3("trap_state", MCU_State_OutBUS, S_TRAP);
    chk1("trap_flag_set", MCU_Trap, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      MCU_Imem_Ready      = 1'b1;
      MCU_Instr_InBUS     = $urandom();
      MCU_Lsu_Ready       = 1'b1;
      MCU_Lsu_Rdata_Valid = 1'b1;
      MCU_Mul_Done        = 1'b1;
      #1;
      chk3("trap_hold_state", MCU_State_OutBUS, S_TRAP);
      chk1("trap_hold_flag", MCU_Trap, 1'b1);
      chk1("trap_imem_req", MCU_Imem_Req, 1'b0);
      chk1("trap_pc_write", MCU_Pc_Write, 1'b0);
      chk1("trap_lsu_valid", MCU_Lsu_Valid, 1'b0);
      chk32("trap_ir", MCU_Ir_OutBUS, 32'h0000007F);
    end
    do_reset();

    // Reset asserted mid-handshake in LSU_REQ
    fetch_issue(32'h0000A103, 1'b1, 1'b1);
    tick();
    #1;
    chk3("midrst_state", MCU_State_OutBUS, S_LSU_REQ);
    chk1("midrst_lsu_valid", MCU_Lsu_Valid, 1'b1);
    do_reset();

    chk32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
